normalize_shift_decoder: RTL
============================

# normalize_shift_decoder

Consumer side of the leading-one priority encoder in the floating-point adder. It takes a raw mantissa together with the encoder's leading-one index and validity flag, and decodes the index into a left-shift amount. The mantissa is normalized iteratively, at most 4 bit positions per cycle, so the leading one lands in the MSB. The exponent is adjusted to match, and the result is delivered over a valid/ready handshake to the rounding stage.

## Interface
Parameters:
- `W`, 24: mantissa width in bits.
- `LW`, 5: leading-one index width; must satisfy 2^LW >= W.
- `EW`, 8: exponent width (unsigned, biased).

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input operand presented.
- `in_ready`  out  1  block can accept an operand.
- `mantissa_in`  in  W  unnormalized mantissa.
- `leading_one_in`  in  LW  bit index of the most significant 1; bit 0 = LSB.
- `validity_in`  in  1  1 = mantissa contains a 1; 0 = mantissa is zero.
- `exponent_in`  in  EW  exponent before normalization.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts the result.
- `mantissa_out`  out  W  normalized mantissa.
- `exponent_out`  out  EW  adjusted exponent.
- `zero_out`  out  1  result is zero.
- `underflow_out`  out  1  required shift exceeded the exponent.

## Operation
- Shift amount S = (W-1) - `leading_one_in`, computed at accept.
- If `leading_one_in` > W-1, the block uses S = 0.
- FSM has three states: IDLE, SHIFT and DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid` & `in_ready`, the block latches the mantissa and latches remaining = S.
  - If `validity_in` = 0: the block forces mantissa = 0, exponent = 0, `zero_out` = 1, `underflow_out` = 0, then goes to DONE.
  - Else if S = 0: the block goes to DONE.
  - Else: the block goes to SHIFT.
- Exponent rule, computed at accept with EW+1 bits: if S > `exponent_in`, then `exponent_out` = 0 and `underflow_out` = 1. Otherwise `exponent_out` = `exponent_in` - S.
  - The mantissa is still fully normalized on underflow.
- SHIFT:
  - If remaining >= 4: the block shifts the mantissa left by 4 and decrements remaining by 4.
  - Otherwise: it shifts left by remaining and sets remaining to 0.
  - Zeros fill from the LSB.
  - When remaining after the step is 0, the block goes to DONE.
- DONE:
  - `out_valid` = 1, and all result outputs are held stable.
  - On `out_ready` = 1, the block goes to IDLE.
  - `in_ready` = 0 in DONE, so there is no overlap: the block holds one operand at a time.
- `in_ready` = 1 only in IDLE, and never during the reset cycle.

## Timing
- Reset values:
  - State is IDLE.
  - `out_valid`, `zero_out` and `underflow_out` are 0.
  - `mantissa_out` and `exponent_out` are 0.
  - `in_ready` is 0 while `reset` is high and 1 in the first cycle after.
- Latency, with the accept edge at T:
  - Zero operand or S = 0: `out_valid` rises at T+1.
  - Otherwise: `out_valid` rises at T+1+ceil(S/4).
  - Maximum, for S = W-1 = 23: T+7.
- Result handshake completes on the edge where `out_valid` & `out_ready`. `in_ready` rises the following cycle.
- Minimum issue interval is latency + 1 cycles.
- Backpressure: while `out_ready` = 0 in DONE, every output stays unchanged for any number of cycles.
- Reset mid-operation, in SHIFT or DONE: the operand is discarded. On the next cycle the block is in IDLE with the reset values above, and no partial result is emitted.
- `in_valid` in a non-IDLE state is ignored; the upstream must hold it until `in_ready`.

## Test plan
- Full shift: `mantissa_in`=0x000001, `leading_one_in`=0, `exponent_in`=30, accepted at T.
  - Expect at T+7: `mantissa_out`=0x800000, `exponent_out`=7, `zero_out`=0, `underflow_out`=0.
- Mixed shift: 0x00F000, index 15, exponent 100 (S=8).
  - Expect at T+3: 0xF00000, exponent 92.
  - Also run 0x0000F0, index 7, exponent 100 (S=16, mixed 4-steps).
  - Expect at T+5: 0xF00000, exponent 84.
- No shift: 0x800000, index 23, exponent 50.
  - Expect at T+1: 0x800000, exponent 50.
  - Also run with `leading_one_in`=31: treated as S=0, output at T+1 with the mantissa unchanged.
- Zero and underflow:
  - `validity_in`=0, any mantissa, exponent 77: expect at T+1 `zero_out`=1, mantissa 0, exponent 0.
  - 0x000010, index 4, exponent 5 (S=19): expect at T+6 mantissa 0x800000, exponent 0, `underflow_out`=1.
- Backpressure:
  - Hold `out_ready`=0 for 3 cycles after `out_valid` rises. Outputs stay stable and `in_ready` stays 0.
  - Raise `out_ready`: `in_ready`=1 the next cycle.
  - Back-to-back operands are each accepted only in IDLE.
- Reset mid-shift: assert `reset` for 1 cycle, 2 cycles after accepting an S=23 operand.
  - Expect `out_valid` never to rise for that operand, and `in_ready`=1 the cycle after reset is released.
  - A new operand then completes correctly.

Source files
------------

// File: rtl/normalize_shift_decoder.sv
// Normalizes a mantissa by a leading-one-derived left shift, at most 4 bits per cycle,
// adjusting the exponent and handing the result downstream over valid/ready.
module normalize_shift_decoder #(
   parameter int unsigned W  = 24,
   parameter int unsigned LW = 5,
   parameter int unsigned EW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  mantissa_in,
   input  logic [LW-1:0] leading_one_in,
   input  logic          validity_in,
   input  logic [EW-1:0] exponent_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  mantissa_out,
   output logic [EW-1:0] exponent_out,
   output logic          zero_out,
   output logic          underflow_out
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   localparam logic [LW-1:0] MaxIdx  = LW'(W - 1);
   localparam logic [LW-1:0] StepMax = LW'(4);

   state_e        state_q, state_d;
   logic [W-1:0]  mant_q, mant_d;
   logic [EW-1:0] exp_q, exp_d;
   logic [LW-1:0] rem_q, rem_d;
   logic          zero_q, zero_d;
   logic          uflow_q, uflow_d;

   logic [LW-1:0] shamt;
   logic [LW-1:0] step;
   logic [EW:0]   exp_ext, sh_ext, exp_diff;
   logic          accept;

   // Out-of-range indices are treated as already normalized.
   always_comb begin
      shamt    = (leading_one_in > MaxIdx) ? '0 : MaxIdx - leading_one_in;
      exp_ext  = {1'b0, exponent_in};
      sh_ext   = (EW + 1)'(shamt);
      exp_diff = exp_ext - sh_ext;
      step     = (rem_q >= StepMax) ? StepMax : rem_q;
      accept   = in_valid && in_ready;
   end

   always_comb begin
      state_d = state_q;
      mant_d  = mant_q;
      exp_d   = exp_q;
      rem_d   = rem_q;
      zero_d  = zero_q;
      uflow_d = uflow_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               mant_d = mantissa_in;
               rem_d  = shamt;
               if (!validity_in) begin
                  mant_d  = '0;
                  exp_d   = '0;
                  rem_d   = '0;
                  zero_d  = 1'b1;
                  uflow_d = 1'b0;
                  state_d = StDone;
               end else begin
                  zero_d = 1'b0;
                  if (sh_ext > exp_ext) begin
                     exp_d   = '0;
                     uflow_d = 1'b1;
                  end else begin
                     exp_d   = exp_diff[EW-1:0];
                     uflow_d = 1'b0;
                  end
                  state_d = (shamt == '0) ? StDone : StShift;
               end
            end
         end
         StShift: begin
            mant_d = mant_q << step;
            rem_d  = rem_q - step;
            if (rem_d == '0) state_d = StDone;
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         mant_q  <= '0;
         exp_q   <= '0;
         rem_q   <= '0;
         zero_q  <= 1'b0;
         uflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mant_q  <= mant_d;
         exp_q   <= exp_d;
         rem_q   <= rem_d;
         zero_q  <= zero_d;
         uflow_q <= uflow_d;
      end
   end

   assign in_ready      = (state_q == StIdle) && !reset;
   assign out_valid     = (state_q == StDone);
   assign mantissa_out  = mant_q;
   assign exponent_out  = exp_q;
   assign zero_out      = zero_q;
   assign underflow_out = uflow_q;

endmodule
